// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: program-memory fetch initiator.
// Owns the word-addressed program counter, pushes {instruction, address}
// pairs into a small prefetch FIFO and hands them to decode over valid/ready.
// A taken-branch redirect reloads the PC and flushes everything fetched.
// Optional feature macro: FETCH_HALT_ON_ZERO_EN (stop fetching on an all-zero word).
module instr_fetch_unit #(
    parameter int                       DATAWIDTH_BUS = 32,
    parameter logic [DATAWIDTH_BUS-1:0] RESET_PC      = 'h0000_0800,
    parameter int                       FIFO_DEPTH    = 2
) (
    input  logic                     fetch_CLOCK_50,
    input  logic                     fetch_RESET_InHigh,
    output logic [DATAWIDTH_BUS-1:0] fetch_BusDirecciones,
    input  logic [DATAWIDTH_BUS-1:0] fetch_BusDatos,
    input  logic                     fetch_Enable,
    input  logic                     fetch_Redirect,
    input  logic [DATAWIDTH_BUS-1:0] fetch_RedirectAddr,
    output logic                     fetch_InstrValid,
    input  logic                     fetch_InstrReady,
    output logic [DATAWIDTH_BUS-1:0] fetch_Instr,
    output logic [DATAWIDTH_BUS-1:0] fetch_InstrAddr,
    output logic                     fetch_Halted
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PTR_W = AW + 1;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

    state_t                   state_reg;
    logic [DATAWIDTH_BUS-1:0] pc_reg;
    logic                     halted_reg;
    logic [PTR_W-1:0]         wr_ptr_reg;
    logic [PTR_W-1:0]         rd_ptr_reg;
    logic [DATAWIDTH_BUS-1:0] data_mem [FIFO_DEPTH];
    logic [DATAWIDTH_BUS-1:0] addr_mem [FIFO_DEPTH];

    logic [PTR_W-1:0] count;
    logic             full;
    logic             empty;
    logic             pop;
    logic             space;
    logic             zero_word;
    logic             fetch_slot;
    logic             push;
    logic             halt_hit;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count = wr_ptr_reg - rd_ptr_reg;
    assign full  = (count == DEPTH_P);
    assign empty = (count == '0);

    // A redirect suppresses both sides of the FIFO for that cycle.
    assign pop   = !empty && fetch_InstrReady && !fetch_Redirect;
    assign space = !full || pop;

`ifdef FETCH_HALT_ON_ZERO_EN
    assign zero_word = (fetch_BusDatos == '0);
`else
    assign zero_word = 1'b0;
`endif

    // A fetch slot is a cycle where a word would be pushed; a zero word
    // (feature enabled) turns that slot into a halt instead.
    assign fetch_slot = (state_reg == FETCH) && !fetch_Redirect && space;
    assign push       = fetch_slot && !zero_word;
    assign halt_hit   = fetch_slot && zero_word;

    assign fetch_BusDirecciones = pc_reg;
    assign fetch_InstrValid     = !empty;
    assign fetch_Instr          = data_mem[rd_ptr_reg[AW-1:0]];
    assign fetch_InstrAddr      = addr_mem[rd_ptr_reg[AW-1:0]];
    assign fetch_Halted         = halted_reg;

    // PC, FIFO storage/pointers and fetch state machine.
    always_ff @(posedge fetch_CLOCK_50 or posedge fetch_RESET_InHigh) begin
        if (fetch_RESET_InHigh) begin
            state_reg  <= IDLE;
            pc_reg     <= RESET_PC;
            halted_reg <= 1'b0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_mem[i] <= '0;
                addr_mem[i] <= '0;
            end
        end else if (fetch_Redirect) begin
            pc_reg     <= fetch_RedirectAddr;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            halted_reg <= 1'b0;
            state_reg  <= fetch_Enable ? FETCH : IDLE;
        end else begin
            if (push) begin
                data_mem[wr_ptr_reg[AW-1:0]] <= fetch_BusDatos;
                addr_mem[wr_ptr_reg[AW-1:0]] <= pc_reg;
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
                pc_reg     <= pc_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (fetch_Enable) state_reg <= FETCH;
                end
                FETCH: begin
                    if (halt_hit) begin
                        state_reg  <= HALT;
                        halted_reg <= 1'b1;
                    end else if (!fetch_Enable) begin
                        state_reg <= IDLE;
                    end
                end
                HALT: begin
                    state_reg <= HALT;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
